// File: rtl/board_disp_sched_pkg.sv
// Shared types and constants for the tear-free board/cursor display scheduler.
package board_disp_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StWaitVbl
  } state_e;

  localparam logic [63:0] BOARD_R_INIT = 64'h0000_0010_0800_0000;
  localparam logic [63:0] BOARD_B_INIT = 64'h0000_0008_1000_0000;

  localparam logic GRANT_ENG = 1'b0;
  localparam logic GRANT_CUR = 1'b1;

endpackage

// File: rtl/board_disp_sched_arb.sv
// disp_rr_arb: two-requester round-robin arbiter; last_grant updates only when a grant is taken.
module disp_rr_arb
  import board_disp_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic eng_req_i,
  input  logic cur_req_i,
  input  logic take_i,
  output logic gnt_o,
  output logic valid_o
);

  logic last_q, last_d;

  always_comb begin
    valid_o = eng_req_i | cur_req_i;
    if (eng_req_i && cur_req_i) begin
      gnt_o = (last_q == GRANT_CUR) ? GRANT_ENG : GRANT_CUR;
    end else if (eng_req_i) begin
      gnt_o = GRANT_ENG;
    end else begin
      gnt_o = GRANT_CUR;
    end
    last_d = (take_i && valid_o) ? gnt_o : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GRANT_CUR;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/board_disp_sched.sv
// Latches engine/cursor updates into a shadow and commits them to the display on vblank.
// Define CURSOR_BLINK_EN to enable the frame counter and cursor blinking.
module board_disp_sched
  import board_disp_sched_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vbl_start_i,
  input  logic        eng_req_i,
  input  logic [63:0] eng_board_r_i,
  input  logic [63:0] eng_board_b_i,
  input  logic [63:0] eng_board_m_i,
  output logic        eng_ack_o,
  input  logic        cur_req_i,
  input  logic [2:0]  cur_x_i,
  input  logic [2:0]  cur_y_i,
  output logic        cur_ack_o,
  output logic [63:0] board_r_o,
  output logic [63:0] board_b_o,
  output logic [63:0] board_m_o,
  output logic [2:0]  coord_x_o,
  output logic [2:0]  coord_y_o,
  output logic        cursor_vis_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        arb_gnt, arb_valid, arb_take;
  logic [63:0] sh_r_q, sh_r_d, sh_b_q, sh_b_d, sh_m_q, sh_m_d;
  logic [2:0]  sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [63:0] disp_r_q, disp_r_d, disp_b_q, disp_b_d, disp_m_q, disp_m_d;
  logic [2:0]  disp_x_q, disp_x_d, disp_y_q, disp_y_d;

  disp_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .eng_req_i (eng_req_i),
    .cur_req_i (cur_req_i),
    .take_i    (arb_take),
    .gnt_o     (arb_gnt),
    .valid_o   (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    arb_take  = 1'b0;
    eng_ack_o = 1'b0;
    cur_ack_o = 1'b0;
    sh_r_d    = sh_r_q;
    sh_b_d    = sh_b_q;
    sh_m_d    = sh_m_q;
    sh_x_d    = sh_x_q;
    sh_y_d    = sh_y_q;
    disp_r_d  = disp_r_q;
    disp_b_d  = disp_b_q;
    disp_m_d  = disp_m_q;
    disp_x_d  = disp_x_q;
    disp_y_d  = disp_y_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          arb_take = 1'b1;
          gnt_d    = arb_gnt;
          state_d  = StLatch;
        end
      end
      StLatch: begin
        // Only the granted requester's fields move; the rest of the shadow is kept.
        if (gnt_q == GRANT_ENG) begin
          sh_r_d    = eng_board_r_i;
          sh_b_d    = eng_board_b_i;
          sh_m_d    = eng_board_m_i;
          eng_ack_o = 1'b1;
        end else begin
          sh_x_d    = cur_x_i;
          sh_y_d    = cur_y_i;
          cur_ack_o = 1'b1;
        end
        state_d = StWaitVbl;
      end
      StWaitVbl: begin
        if (vbl_start_i) begin
          disp_r_d = sh_r_q;
          disp_b_d = sh_b_q;
          disp_m_d = sh_m_q;
          disp_x_d = sh_x_q;
          disp_y_d = sh_y_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= GRANT_CUR;
      sh_r_q   <= BOARD_R_INIT;
      sh_b_q   <= BOARD_B_INIT;
      sh_m_q   <= '0;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      disp_r_q <= BOARD_R_INIT;
      disp_b_q <= BOARD_B_INIT;
      disp_m_q <= '0;
      disp_x_q <= '0;
      disp_y_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sh_r_q   <= sh_r_d;
      sh_b_q   <= sh_b_d;
      sh_m_q   <= sh_m_d;
      sh_x_q   <= sh_x_d;
      sh_y_q   <= sh_y_d;
      disp_r_q <= disp_r_d;
      disp_b_q <= disp_b_d;
      disp_m_q <= disp_m_d;
      disp_x_q <= disp_x_d;
      disp_y_q <= disp_y_d;
    end
  end

  assign board_r_o = disp_r_q;
  assign board_b_o = disp_b_q;
  assign board_m_o = disp_m_q;
  assign coord_x_o = disp_x_q;
  assign coord_y_o = disp_y_q;
  assign busy_o    = (state_q != StIdle);

`ifdef CURSOR_BLINK_EN
  localparam logic [7:0] FrameLast = 8'(BLINK_FRAMES - 1);

  logic [7:0] frame_q, frame_d;
  logic       vis_q, vis_d;
  logic       cur_commit;

  assign cur_commit = (state_q == StWaitVbl) && vbl_start_i && (gnt_q == GRANT_CUR);

  always_comb begin
    frame_d = frame_q;
    vis_d   = vis_q;
    if (cur_commit) begin
      frame_d = '0;
      vis_d   = 1'b1;
    end else if (vbl_start_i) begin
      if (frame_q == FrameLast) begin
        frame_d = '0;
        vis_d   = ~vis_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      frame_q <= frame_d;
      vis_q   <= vis_d;
    end
  end

  assign cursor_vis_o = vis_q;
`else
  // Constant high for any legal BLINK_FRAMES.
  assign cursor_vis_o = (BLINK_FRAMES != 0);
`endif

endmodule

// File: tb/tb_board_disp_sched.sv
// Self-checking bench for board_disp_sched: vector table, commit scoreboard, corner sequences.
module tb_board_disp_sched;

  localparam logic [63:0] R0   = 64'h0000_0010_0800_0000;
  localparam logic [63:0] B0   = 64'h0000_0008_1000_0000;
  localparam logic [63:0] GARB = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic [63:0] r;
    logic [63:0] b;
    logic [63:0] m;
    logic [2:0]  x;
    logic [2:0]  y;
  } disp_t;

  typedef struct {
    bit          is_cur;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [63:0] r;
    logic [63:0] b;
    logic [63:0] m;
    int          delay;
    disp_t       exp;
  } vec_t;

  logic        clk, rst_n, vbl_start;
  logic        eng_req, eng_ack, cur_req, cur_ack;
  logic [63:0] eng_r, eng_b, eng_m;
  logic [2:0]  cur_x, cur_y;
  logic [63:0] board_r, board_b, board_m;
  logic [2:0]  coord_x, coord_y;
  logic        cursor_vis, busy;

  int    n_tests = 0;
  int    n_fail  = 0;
  disp_t exp_q[$];
  disp_t shown;
  disp_t mon_prev;
  bit    mon_valid = 0;
  vec_t  tbl[5];

  board_disp_sched #(.BLINK_FRAMES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vbl_start_i   (vbl_start),
    .eng_req_i     (eng_req),
    .eng_board_r_i (eng_r),
    .eng_board_b_i (eng_b),
    .eng_board_m_i (eng_m),
    .eng_ack_o     (eng_ack),
    .cur_req_i     (cur_req),
    .cur_x_i       (cur_x),
    .cur_y_i       (cur_y),
    .cur_ack_o     (cur_ack),
    .board_r_o     (board_r),
    .board_b_o     (board_b),
    .board_m_o     (board_m),
    .coord_x_o     (coord_x),
    .coord_y_o     (coord_y),
    .cursor_vis_o  (cursor_vis),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Requesters must hold their request until acked.
  logic eng_pend_q, cur_pend_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_pend_q <= 1'b0;
      cur_pend_q <= 1'b0;
    end else begin
      if (eng_pend_q) assert (eng_req) else $error("protocol violation: eng_req dropped early");
      if (cur_pend_q) assert (cur_req) else $error("protocol violation: cur_req dropped early");
      eng_pend_q <= eng_req && !eng_ack;
      cur_pend_q <= cur_req && !cur_ack;
    end
  end

  function automatic disp_t cur_disp();
    disp_t d;
    d.r = board_r;
    d.b = board_b;
    d.m = board_m;
    d.x = coord_x;
    d.y = coord_y;
    return d;
  endfunction

  function automatic disp_t mk_disp(logic [63:0] r, logic [63:0] b, logic [63:0] m,
                                    logic [2:0] x, logic [2:0] y);
    disp_t d;
    d.r = r;
    d.b = b;
    d.m = m;
    d.x = x;
    d.y = y;
    return d;
  endfunction

  function automatic vec_t mk_vec(bit c, logic [2:0] x, logic [2:0] y, logic [63:0] r,
                                  logic [63:0] b, logic [63:0] m, int delay, disp_t exp);
    vec_t v;
    v.is_cur = c;
    v.x      = x;
    v.y      = y;
    v.r      = r;
    v.b      = b;
    v.m      = m;
    v.delay  = delay;
    v.exp    = exp;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_disp(string name, disp_t act, disp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got r=%h b=%h m=%h x=%0d y=%0d expected r=%h b=%h m=%h x=%0d y=%0d",
               name, act.r, act.b, act.m, act.x, act.y, exp.r, exp.b, exp.m, exp.x, exp.y);
    end
  endtask

  // Scoreboard: every change of the displayed state must match the next queued commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_valid = 0;
    end else begin
      if (mon_valid && cur_disp() !== mon_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_commit: got x=%0d y=%0d m=%h, none expected",
                   coord_x, coord_y, board_m);
        end else begin
          chk_disp("commit_order", cur_disp(), exp_q.pop_front());
        end
      end
      mon_prev  = cur_disp();
      mon_valid = 1;
    end
  end

  // Waits (bounded) for either ack; n counts negedges since the request was raised.
  task automatic wait_any(output bit ge, output bit gc, output int n);
    n  = 0;
    ge = 0;
    gc = 0;
    while (!(ge || gc) && n < 20) begin
      @(negedge clk);
      n++;
      ge = eng_ack;
      gc = cur_ack;
    end
  endtask

  task automatic do_txn(input vec_t v);
    bit ge, gc;
    int n;
    if (v.is_cur) begin
      cur_req = 1'b1; cur_x = v.x; cur_y = v.y;
      eng_r = GARB; eng_b = GARB; eng_m = GARB;
    end else begin
      eng_req = 1'b1; eng_r = v.r; eng_b = v.b; eng_m = v.m;
      cur_x = 3'd6; cur_y = 3'd6;
    end
    exp_q.push_back(v.exp);
    wait_any(ge, gc, n);
    chk("ack_latency", 64'(n), 64'd2);
    chk("ack_select", {62'd0, ge, gc}, v.is_cur ? 64'd1 : 64'd2);
    @(posedge clk); #1;
    eng_req = 1'b0;
    cur_req = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {62'd0, eng_ack, cur_ack}, 64'd0);
    chk("busy_in_wait", 64'(busy), 64'd1);
    chk_disp("hold_after_ack", cur_disp(), shown);
    @(posedge clk); #1;
    repeat (v.delay) begin
      @(negedge clk);
      chk_disp("hold_wait", cur_disp(), shown);
      @(posedge clk); #1;
    end
    vbl_start = 1'b1;
    @(negedge clk);
    chk_disp("hold_pre_vbl", cur_disp(), shown);
    @(posedge clk); #1;
    vbl_start = 1'b0;
    @(negedge clk);
    chk_disp("commit", cur_disp(), v.exp);
    chk("busy_after_commit", 64'(busy), 64'd0);
    shown = v.exp;
    @(posedge clk); #1;
  endtask

  task automatic pulse_vbl();
    vbl_start = 1'b1;
    @(posedge clk); #1;
    vbl_start = 1'b0;
  endtask

  initial begin
    bit    ge, gc;
    int    n;
    disp_t e1, e2, e3;
    int    mcnt;
    bit    mvis;

    rst_n = 1'b0; vbl_start = 1'b0;
    eng_req = 1'b0; eng_r = '0; eng_b = '0; eng_m = '0;
    cur_req = 1'b0; cur_x = '0; cur_y = '0;

    tbl[0] = mk_vec(1, 3'd5, 3'd2, '0, '0, '0, 10, mk_disp(R0, B0, '0, 3'd5, 3'd2));
    tbl[1] = mk_vec(0, '0, '0, 64'h00FF_0000_0000_FF00, 64'h0000_00FF_FF00_0000, 64'h81, 3,
                    mk_disp(64'h00FF_0000_0000_FF00, 64'h0000_00FF_FF00_0000, 64'h81,
                            3'd5, 3'd2));
    tbl[2] = mk_vec(1, 3'd7, 3'd0, '0, '0, '0, 1,
                    mk_disp(64'h00FF_0000_0000_FF00, 64'h0000_00FF_FF00_0000, 64'h81,
                            3'd7, 3'd0));
    tbl[3] = mk_vec(0, '0, '0, 64'h8100_0000_0000_0000, 64'h42, 64'h0123_4567_89AB_CDEF, 0,
                    mk_disp(64'h8100_0000_0000_0000, 64'h42, 64'h0123_4567_89AB_CDEF,
                            3'd7, 3'd0));
    tbl[4] = mk_vec(1, 3'd0, 3'd7, '0, '0, '0, 5,
                    mk_disp(64'h8100_0000_0000_0000, 64'h42, 64'h0123_4567_89AB_CDEF,
                            3'd0, 3'd7));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_board_r", board_r, R0);
    chk("rst_board_b", board_b, B0);
    chk("rst_board_m", board_m, 64'd0);
    chk("rst_coord", {58'd0, coord_x, coord_y}, 64'd0);
    chk("rst_cursor_vis", 64'(cursor_vis), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acks", {62'd0, eng_ack, cur_ack}, 64'd0);
    shown = mk_disp(R0, B0, '0, '0, '0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) do_txn(tbl[i]);

    // vblank while idle must not disturb the display
    pulse_vbl();
    @(negedge clk);
    chk_disp("idle_vbl_hold", cur_disp(), shown);
    @(posedge clk); #1;

    // vblank during LATCH is ignored; commit waits for the next one
    eng_req = 1'b1; eng_r = 64'h5; eng_b = 64'h6; eng_m = 64'hFF;
    e1 = mk_disp(64'h5, 64'h6, 64'hFF, shown.x, shown.y);
    exp_q.push_back(e1);
    @(posedge clk); #1;
    vbl_start = 1'b1;
    @(negedge clk);
    chk("latch_vbl_ack", 64'(eng_ack), 64'd1);
    @(posedge clk); #1;
    vbl_start = 1'b0;
    eng_req   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_disp("latch_vbl_no_commit", cur_disp(), shown);
      @(posedge clk); #1;
    end
    pulse_vbl();
    @(negedge clk);
    chk_disp("latch_vbl_late_commit", cur_disp(), e1);
    shown = e1;
    @(posedge clk); #1;

    // Round-robin ties after a fresh reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    shown = mk_disp(R0, B0, '0, '0, '0);
    eng_req = 1'b1; eng_r = 64'hAAAA_0000_0000_5555; eng_b = 64'h0000_BBBB_CCCC_0000;
    eng_m = 64'h3C;
    cur_req = 1'b1; cur_x = 3'd3; cur_y = 3'd4;
    e1 = mk_disp(64'hAAAA_0000_0000_5555, 64'h0000_BBBB_CCCC_0000, 64'h3C, 3'd0, 3'd0);
    e2 = mk_disp(64'hAAAA_0000_0000_5555, 64'h0000_BBBB_CCCC_0000, 64'h3C, 3'd3, 3'd4);
    e3 = mk_disp(64'h1, 64'h2, 64'h4, 3'd3, 3'd4);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    wait_any(ge, gc, n);
    chk("tie1_latency", 64'(n), 64'd2);
    chk("tie1_grant_eng", {62'd0, ge, gc}, 64'd2);
    @(posedge clk); #1;
    eng_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("tie1_cur_pending", 64'(cur_ack), 64'd0);
      @(posedge clk); #1;
    end
    eng_req = 1'b1; eng_r = 64'h1; eng_b = 64'h2; eng_m = 64'h4;
    exp_q.push_back(e3);
    pulse_vbl();
    wait_any(ge, gc, n);
    chk_disp("tie1_commit", cur_disp(), e1);
    chk("tie2_grant_cur", {62'd0, ge, gc}, 64'd1);
    chk("tie2_latency", 64'(n), 64'd2);
    @(posedge clk); #1;
    cur_req = 1'b0;
    @(negedge clk);
    chk("tie2_eng_pending", 64'(eng_ack), 64'd0);
    @(posedge clk); #1;
    pulse_vbl();
    wait_any(ge, gc, n);
    chk_disp("tie2_commit", cur_disp(), e2);
    chk("tie3_grant_eng", {62'd0, ge, gc}, 64'd2);
    @(posedge clk); #1;
    eng_req = 1'b0;
    pulse_vbl();
    @(negedge clk);
    chk_disp("tie3_commit", cur_disp(), e3);
    shown = e3;
    @(posedge clk); #1;

    // Reset while (7,7) is latched; the pending engine request is re-served afterwards
    cur_req = 1'b1; cur_x = 3'd7; cur_y = 3'd7;
    wait_any(ge, gc, n);
    chk("rst_mid_cur_ack", {62'd0, ge, gc}, 64'd1);
    @(posedge clk); #1;
    cur_req = 1'b0;
    eng_req = 1'b1; eng_r = 64'h0000_0000_FFFF_0000; eng_b = 64'h0F;
    eng_m = 64'hF000_0000_0000_0000;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_coord", {58'd0, coord_x, coord_y}, 64'd0);
    chk_disp("rst_mid_disp", cur_disp(), mk_disp(R0, B0, '0, '0, '0));
    chk("rst_mid_busy_low", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    shown = mk_disp(R0, B0, '0, '0, '0);
    e1 = mk_disp(64'h0000_0000_FFFF_0000, 64'h0F, 64'hF000_0000_0000_0000, 3'd0, 3'd0);
    exp_q.push_back(e1);
    wait_any(ge, gc, n);
    chk("rst_reserve_grant", {62'd0, ge, gc}, 64'd2);
    chk("rst_reserve_latency", 64'(n), 64'd2);
    @(posedge clk); #1;
    eng_req = 1'b0;
    pulse_vbl();
    @(negedge clk);
    chk_disp("rst_reserve_commit", cur_disp(), e1);
    shown = e1;
    @(posedge clk); #1;

`ifdef CURSOR_BLINK_EN
    do_txn(mk_vec(1, 3'd1, 3'd1, '0, '0, '0, 0, mk_disp(shown.r, shown.b, shown.m, 3'd1, 3'd1)));
    chk("blink_vis_after_cur", 64'(cursor_vis), 64'd1);
    mcnt = 0;
    mvis = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pulse_vbl();
      mcnt++;
      if (mcnt == 2) begin
        mcnt = 0;
        mvis = ~mvis;
      end
      @(negedge clk);
      chk("blink_vis", 64'(cursor_vis), 64'(mvis));
      @(posedge clk); #1;
    end
    do_txn(mk_vec(1, 3'd2, 3'd2, '0, '0, '0, 0, mk_disp(shown.r, shown.b, shown.m, 3'd2, 3'd2)));
    chk("blink_forced_vis", 64'(cursor_vis), 64'd1);
`else
    mcnt = 0;
    mvis = 1'b1;
    repeat (3) begin
      pulse_vbl();
      mcnt++;
      @(negedge clk);
      chk("vis_constant", 64'(cursor_vis), 64'(mvis));
      @(posedge clk); #1;
    end
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
